// File: rtl/inst_loader.sv
// inst_loader: boot-time program loader. Parses a framed byte stream
// (sync, 16-bit word count, little-endian payload words, 8-bit checksum),
// writes the payload into instruction RAM through the debug port and keeps
// the core in reset until a frame has been fully written and verified.
module inst_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 4096,
    parameter int          TIMEOUT   = 1_000_000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        cpu_rst,
    output logic [31:0] inst_a2,
    output logic [31:0] inst_wd2,
    output logic [3:0]  inst_we2,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    // Wide enough to hold TIMEOUT-1 for any legal TIMEOUT.
    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t        state;
    state_t        state_next;
    logic [1:0]    err_next;
    logic [7:0]    len_lo;
    logic [15:0]   len_words;
    logic [15:0]   word_idx;
    logic [1:0]    lane;
    logic [23:0]   word_buf;
    logic [7:0]    csum;
    logic [TW-1:0] tmo_cnt;

    logic          in_frame;
    logic          tmo_hit;
    logic [15:0]   len_full;
    logic          len_bad;
    logic          last_word;

    assign in_frame  = (state == LEN_LO) || (state == LEN_HI) ||
                       (state == DATA)   || (state == CSUM);
    // A byte in the expiry cycle keeps the frame alive.
    assign tmo_hit   = in_frame && !rx_valid && (tmo_cnt == TW'(TIMEOUT - 1));
    assign len_full  = {rx_data, len_lo};
    assign len_bad   = (len_full == 16'd0) || (32'(len_full) > 32'(MAX_WORDS));
    assign last_word = (lane == 2'd3) && (word_idx == len_words - 16'd1);

    // Next-state and error-code selection; moves only on a byte or on timeout.
    always_comb begin
        state_next = state;
        err_next   = err;
        if (tmo_hit) begin
            state_next = ERR;
            err_next   = 2'd3;
        end else if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == SYNC_BYTE) state_next = LEN_LO;
                end
                LEN_LO: state_next = LEN_HI;
                LEN_HI: begin
                    if (len_bad) begin
                        state_next = ERR;
                        err_next   = 2'd1;
                    end else begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    if (last_word) state_next = CSUM;
                end
                CSUM: begin
                    if (rx_data == csum) begin
                        state_next = DONE;
                    end else begin
                        state_next = ERR;
                        err_next   = 2'd2;
                    end
                end
                DONE, ERR: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_next = LEN_LO;
                        err_next   = 2'd0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, registered status decodes, word assembly and the write strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            err       <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cpu_rst   <= 1'b1;
            inst_we2  <= 4'h0;
            inst_a2   <= 32'h0;
            inst_wd2  <= 32'h0;
            len_lo    <= 8'h0;
            len_words <= 16'h0;
            word_idx  <= 16'h0;
            lane      <= 2'd0;
            word_buf  <= 24'h0;
            csum      <= 8'h0;
            tmo_cnt   <= '0;
        end else begin
            state    <= state_next;
            err      <= err_next;
            busy     <= (state_next == LEN_LO) || (state_next == LEN_HI) ||
                        (state_next == DATA)   || (state_next == CSUM);
            done     <= (state_next == DONE);
            cpu_rst  <= (state_next != DONE);
            inst_we2 <= 4'h0;
            tmo_cnt  <= (!in_frame || rx_valid) ? '0 : tmo_cnt + TW'(1);

            if (rx_valid) begin
                case (state)
                    LEN_LO: len_lo <= rx_data;
                    LEN_HI: begin
                        len_words <= len_full;
                        word_idx  <= 16'h0;
                        lane      <= 2'd0;
                        csum      <= 8'h0;
                    end
                    DATA: begin
                        csum <= csum + rx_data;
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            inst_we2 <= 4'hF;
                            inst_a2  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                            inst_wd2 <= {rx_data, word_buf};
                            word_idx <= word_idx + 16'd1;
                        end else begin
                            word_buf[{lane, 3'b000} +: 8] <= rx_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
